alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter that shares the core's single `alu` instance between a primary requester (execute stage) and a secondary requester (e.g. branch/address helper).
- Accepts operand bundles over valid/ready handshakes.
- Registers the granted bundle onto the ALU inputs.
- Captures the ALU result and flags one cycle later into a per-requester one-entry response register with its own valid/ready handshake.
- Sits between the requesters and the `alu` module; the ALU itself stays purely combinational.

## Interface
- `XLEN`, default 32: datapath width; matches the core's `XLEN.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rstn`  in  1  reset, synchronous and active-low.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when valid&ready.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  XLEN  operands.
- `req0_shamt` / `req1_shamt`  in  5  shift amount.
- `req0_aluctrl` / `req1_aluctrl`  in  4  ALU control code.
- `alu_a`, `alu_b`  out  XLEN  registered operands to ALU.
- `alu_shamt`  out  5  registered shift amount.
- `alu_aluctrl`  out  4  registered control code.
- `alu_aluout`  in  XLEN  ALU result.
- `alu_overflow`, `alu_zero`, `alu_lt`, `alu_ge`  in  1 each  ALU flags.
- `rsp0_valid` / `rsp1_valid`  out  1  response held.
- `rsp0_ready` / `rsp1_ready`  in  1  consumer takes response.
- `rsp0_data` / `rsp1_data`  out  XLEN  captured result.
- `rsp0_flags` / `rsp1_flags`  out  4  captured {overflow, zero, lt, ge}.

## Operation
- **FSM**: two states, S_IDLE and S_EXEC.
- **Eligibility**: requester i is eligible when `reqi_valid` is high and its slot is free. Free means `rspi_valid`==0, or `rspi_valid`&`rspi_ready` in the same cycle.
- **S_IDLE arbitration**:
  - If no requester is eligible: stay in S_IDLE.
  - If one is eligible: grant it.
  - If both are eligible: grant the one ≠ `last_grant`.
- **On grant**:
  - Assert `reqi_ready` for the granted requester only (combinational, this cycle).
  - Latch a/b/shamt/aluctrl into the `alu_*` registers.
  - Set `owner`=i and `last_grant`=i.
  - Go to S_EXEC.
- **S_EXEC**:
  - Both `req*_ready`=0.
  - At the end of the cycle, capture `alu_aluout` into `rsp[owner]_data`, capture `{alu_overflow, alu_zero, alu_lt, alu_ge}` into `rsp[owner]_flags`, and set `rsp[owner]_valid`=1.
  - Return to S_IDLE.
- **`alu_*` registers**: change only on grant; they hold their value otherwise.
- **Response registers**:
  - `rspi_valid` clears on `rspi_valid`&`rspi_ready` unless a capture for i occurs in the same edge; capture wins and sets it.
  - `rspi_data`/`rspi_flags` are stable while valid&!ready.
- **Requesters**: must hold their bundle stable while valid&!ready. The arbiter never drops or reorders a requester's operations; each requester's responses come back in its own issue order.

## Timing
- **Reset values** (`rstn`=0 sampled at an edge): state=S_IDLE; `last_grant`=1 (requester 0 wins the first tie); `alu_a`=`alu_b`=0; `alu_shamt`=0; `alu_aluctrl`=4'b0000; `rsp0_valid`=`rsp1_valid`=0; `rsp*_data`=0; `rsp*_flags`=0; `req*_ready`=0 while `rstn`=0.
- **Latency**: handshake in cycle T → operands on `alu_*` in T+1 → `rspi_valid`=1 in T+2.
- **Throughput**: one operation per 2 cycles; the next grant is possible in T+2.
- **Backpressure**: a full slot (`rspi_valid`=1, `rspi_ready`=0) makes requester i ineligible. The other requester may still be granted.
- **Simultaneous drain + accept**: in S_IDLE, if `rspi_ready` drains the slot in the same cycle, requester i may be granted.
- **Reset mid-op**: reset in S_EXEC aborts the operation. No response is produced and the state is fully reinitialised as above.
- **Combinational paths**: `req*_ready` depends combinationally on `req*_valid`, `rsp*_valid`, `rsp*_ready`, state and `last_grant`. There is no combinational path from `alu_*` inputs to any output.

## Test plan
- **Single op**: req0 ADDU (4'b0010), a=5, b=7, accepted at T → `alu_a`=5/`alu_b`=7 at T+1; `rsp0_valid`=1 at T+2, `rsp0_data`=12, `rsp0_flags`[2] (zero)=0; holds until `rsp0_ready`.
- **Tie after reset**: req0 and req1 valid in the same cycle T → req0 granted at T, req1 granted at T+2; `rsp0_valid` at T+2, `rsp1_valid` at T+4.
- **Fairness**: both requesters continuously valid, `rsp*_ready`=1 → grant sequence 0,1,0,1,… one grant every 2 cycles, no starvation over 20 ops.
- **Backpressure**:
  - `rsp0_valid`=1 with `rsp0_ready`=0 and req0 valid → `req0_ready` stays 0; req1 SUBU a=3, b=3 is served and returns data 0 with zero flag=1.
  - When `rsp0_ready` rises in S_IDLE, req0 is granted that same cycle.
- **Flags/results**: req1 SLTU (4'b1100) a=1, b=2 → `rsp1_data`=1. req0 SUBU a=0, b=1 → `rsp0_data`=32'hFFFFFFFF, lt flag=1.
- **Reset mid-op**: `rstn`=0 during S_EXEC → after that edge, both `rsp*_valid`=0, `alu_*`=0, and no response appears. The next tie is granted to req0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
//
// Bundles every handshake and datapath signal around alu_arbiter:
//   - two request channels (reqN_valid/ready + a, b, shamt, aluctrl)
//   - the registered operand bus towards the shared ALU and its result/flags
//   - two response channels (rspN_valid/ready + data, flags)
//
// Modports:
//   slave  : the arbiter's view (consumes requests, drives ALU inputs and
//            responses).
//   master : the surroundings' view (requesters, response consumers and the
//            combinational ALU).
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int XLEN = 32
) ();

  // Request channel 0 (primary / execute stage)
  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic [4:0]      req0_shamt;
  logic [3:0]      req0_aluctrl;

  // Request channel 1 (secondary / helper)
  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [4:0]      req1_shamt;
  logic [3:0]      req1_aluctrl;

  // Shared ALU: registered operands out, combinational result/flags back
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      alu_shamt;
  logic [3:0]      alu_aluctrl;
  logic [XLEN-1:0] alu_aluout;
  logic            alu_overflow;
  logic            alu_zero;
  logic            alu_lt;
  logic            alu_ge;

  // Response channels; flags are {overflow, zero, lt, ge}
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [XLEN-1:0] rsp0_data;
  logic [3:0]      rsp0_flags;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [XLEN-1:0] rsp1_data;
  logic [3:0]      rsp1_flags;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_shamt, req0_aluctrl,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_shamt, req1_aluctrl,
    output req1_ready,
    output alu_a, alu_b, alu_shamt, alu_aluctrl,
    input  alu_aluout, alu_overflow, alu_zero, alu_lt, alu_ge,
    output rsp0_valid, rsp0_data, rsp0_flags,
    input  rsp0_ready,
    output rsp1_valid, rsp1_data, rsp1_flags,
    input  rsp1_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_shamt, req0_aluctrl,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_shamt, req1_aluctrl,
    input  req1_ready,
    input  alu_a, alu_b, alu_shamt, alu_aluctrl,
    output alu_aluout, alu_overflow, alu_zero, alu_lt, alu_ge,
    input  rsp0_valid, rsp0_data, rsp0_flags,
    output rsp0_ready,
    input  rsp1_valid, rsp1_data, rsp1_flags,
    output rsp1_ready
  );

endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Round-robin arbiter sharing one purely combinational ALU between two
// requesters. A granted operand bundle is registered onto the ALU inputs;
// one cycle later the ALU result and flags are captured into the owner's
// one-entry response register, which is then offered on its own valid/ready
// handshake. One operation every two cycles.
//
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   rstn  : synchronous active-low reset
//   bus   : alu_arbiter_if.slave (requests, ALU operand/result bus, responses)
//
// Timing: request handshake in T -> alu_* valid in T+1 -> rspN_valid in T+2.
// Outputs other than reqN_ready are straight from registers, so there is no
// combinational path from the ALU result/flags to any output.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rstn,
  alu_arbiter_if.slave bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;

  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [4:0]      alu_shamt_q, alu_shamt_d;
  logic [3:0]      alu_aluctrl_q, alu_aluctrl_d;

  logic [1:0]      rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp0_data_q, rsp0_data_d;
  logic [XLEN-1:0] rsp1_data_q, rsp1_data_d;
  logic [3:0]      rsp0_flags_q, rsp0_flags_d;
  logic [3:0]      rsp1_flags_q, rsp1_flags_d;

  logic [1:0]      req_valid;
  logic [1:0]      rsp_ready;
  logic [1:0]      eligible;
  logic [1:0]      req_ready;
  logic            grant_idx;
  logic [3:0]      alu_flags;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign alu_flags = {bus.alu_overflow, bus.alu_zero, bus.alu_lt, bus.alu_ge};

  // A slot is free when empty or being drained this very cycle, so a
  // requester can be granted in the same cycle its old response leaves.
  assign eligible  = req_valid & (~rsp_valid_q | rsp_ready);

  // ---------------------------------------------------------------------------
  // Next-state and grant logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_shamt_d   = alu_shamt_q;
    alu_aluctrl_d = alu_aluctrl_q;
    rsp0_data_d   = rsp0_data_q;
    rsp1_data_d   = rsp1_data_q;
    rsp0_flags_d  = rsp0_flags_q;
    rsp1_flags_d  = rsp1_flags_q;
    req_ready     = 2'b00;
    grant_idx     = 1'b0;

    // Drain first; a capture below for the same slot overrides the clear.
    rsp_valid_d   = rsp_valid_q & ~rsp_ready;

    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          // On a tie the requester that did not win last time goes next;
          // otherwise the single eligible one is picked.
          grant_idx            = (&eligible) ? ~last_grant_q : eligible[1];
          req_ready[grant_idx] = 1'b1;
          alu_a_d              = grant_idx ? bus.req1_a       : bus.req0_a;
          alu_b_d              = grant_idx ? bus.req1_b       : bus.req0_b;
          alu_shamt_d          = grant_idx ? bus.req1_shamt   : bus.req0_shamt;
          alu_aluctrl_d        = grant_idx ? bus.req1_aluctrl : bus.req0_aluctrl;
          owner_d              = grant_idx;
          last_grant_d         = grant_idx;
          state_d              = S_EXEC;
        end
      end

      S_EXEC: begin
        // The ALU has seen the registered operands for a full cycle; take
        // its result into the owner's response slot.
        rsp_valid_d[owner_q] = 1'b1;
        if (owner_q) begin
          rsp1_data_d  = bus.alu_aluout;
          rsp1_flags_d = alu_flags;
        end else begin
          rsp0_data_d  = bus.alu_aluout;
          rsp0_flags_d = alu_flags;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge value of its inputs regardless of statement order.
    if (!rstn) begin
      state_q       <= S_IDLE;
      // Requester 0 wins the first tie after reset.
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_shamt_q   <= '0;
      alu_aluctrl_q <= '0;
      rsp_valid_q   <= 2'b00;
      // NOTE: the datapath registers are reset as well, not just the valid
      // bits, because alu_* and rsp*_data are visible outputs whose
      // post-reset value consumers may observe.
      rsp0_data_q   <= '0;
      rsp1_data_q   <= '0;
      rsp0_flags_q  <= '0;
      rsp1_flags_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_shamt_q   <= alu_shamt_d;
      alu_aluctrl_q <= alu_aluctrl_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp0_data_q   <= rsp0_data_d;
      rsp1_data_q   <= rsp1_data_d;
      rsp0_flags_q  <= rsp0_flags_d;
      rsp1_flags_q  <= rsp1_flags_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Ready is held low while reset is asserted so nothing is accepted into a
  // machine that is being reinitialised on this edge.
  assign bus.req0_ready  = rstn & req_ready[0];
  assign bus.req1_ready  = rstn & req_ready[1];

  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_shamt   = alu_shamt_q;
  assign bus.alu_aluctrl = alu_aluctrl_q;

  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp0_data   = rsp0_data_q;
  assign bus.rsp0_flags  = rsp0_flags_q;
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp1_data   = rsp1_data_q;
  assign bus.rsp1_flags  = rsp1_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A behavioural ALU drives the result
// bus from the registered operands. A transaction-level model (busy flag,
// last winner, per-requester response slot) predicts ready, the ALU operand
// registers and the response registers every cycle. Directed sequences cover
// the listed scenarios, then a randomized phase runs.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADDU = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SUBU = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b1100;

  logic clk;
  logic rstn;

  alu_arbiter_if #(.XLEN(XLEN)) bus ();

  alu_arbiter #(.XLEN(XLEN)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: returns {overflow, zero, lt, ge, result}
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh, input logic [3:0] op);
    logic [31:0] r;
    logic        ov;
    logic        lt;
    ov = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADDU: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUBU: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  r = b << sh;
      OP_SRL:  r = b >> sh;
      default: r = 32'd0;
    endcase
    lt = $signed(a) < $signed(b);
    return {ov, (r == 32'd0), lt, ~lt, r};
  endfunction

  logic [35:0] alu_res;
  always_comb begin
    alu_res          = ref_alu(bus.alu_a, bus.alu_b, bus.alu_shamt, bus.alu_aluctrl);
    bus.alu_aluout   = alu_res[31:0];
    bus.alu_overflow = alu_res[35];
    bus.alu_zero     = alu_res[34];
    bus.alu_lt       = alu_res[33];
    bus.alu_ge       = alu_res[32];
  end

  // Stimulus state
  logic        v  [2];
  logic [31:0] a  [2];
  logic [31:0] b  [2];
  logic [4:0]  sh [2];
  logic [3:0]  op [2];
  logic        rr [2];
  logic [1:0]  acc;
  logic [1:0]  last_rdy;

  // Reference model
  bit          m_busy;
  int          m_owner;
  int          m_last;
  logic        m_rv [2];
  logic [31:0] m_rd [2];
  logic [3:0]  m_rf [2];
  logic [31:0] m_a, m_b;
  logic [4:0]  m_sh;
  logic [3:0]  m_op;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic reset_model();
    m_busy = 0; m_owner = 0; m_last = 1;
    m_a = '0; m_b = '0; m_sh = '0; m_op = '0;
    for (int i = 0; i < 2; i++) begin
      m_rv[i] = 1'b0; m_rd[i] = '0; m_rf[i] = '0;
    end
  endtask

  // One clock cycle: entered at a negedge with stimulus variables set,
  // returns at the next negedge with the model advanced past the posedge.
  task automatic step();
    int          g;
    bit          e0, e1;
    logic [1:0]  exp_rdy;
    logic [35:0] res;
    bus.req0_valid = v[0]; bus.req0_a = a[0]; bus.req0_b = b[0];
    bus.req0_shamt = sh[0]; bus.req0_aluctrl = op[0];
    bus.req1_valid = v[1]; bus.req1_a = a[1]; bus.req1_b = b[1];
    bus.req1_shamt = sh[1]; bus.req1_aluctrl = op[1];
    bus.rsp0_ready = rr[0]; bus.rsp1_ready = rr[1];
    #1;
    check("alu_a",       bus.alu_a,       m_a);
    check("alu_b",       bus.alu_b,       m_b);
    check("alu_shamt",   bus.alu_shamt,   m_sh);
    check("alu_aluctrl", bus.alu_aluctrl, m_op);
    check("rsp0_valid",  bus.rsp0_valid,  m_rv[0]);
    check("rsp0_data",   bus.rsp0_data,   m_rd[0]);
    check("rsp0_flags",  bus.rsp0_flags,  m_rf[0]);
    check("rsp1_valid",  bus.rsp1_valid,  m_rv[1]);
    check("rsp1_data",   bus.rsp1_data,   m_rd[1]);
    check("rsp1_flags",  bus.rsp1_flags,  m_rf[1]);

    g = -1;
    if (rstn && !m_busy) begin
      e0 = v[0] && (!m_rv[0] || rr[0]);
      e1 = v[1] && (!m_rv[1] || rr[1]);
      if (e0 && e1) g = 1 - m_last;
      else if (e0)  g = 0;
      else if (e1)  g = 1;
    end
    exp_rdy = 2'b00;
    if (g >= 0) exp_rdy[g] = 1'b1;
    last_rdy = {bus.req1_ready, bus.req0_ready};
    check("req_ready", last_rdy, exp_rdy);

    if (!rstn) begin
      reset_model();
    end else begin
      for (int i = 0; i < 2; i++) if (m_rv[i] && rr[i]) m_rv[i] = 1'b0;
      if (m_busy) begin
        res = ref_alu(m_a, m_b, m_sh, m_op);
        m_rv[m_owner] = 1'b1;
        m_rd[m_owner] = res[31:0];
        m_rf[m_owner] = res[35:32];
        m_busy = 0;
      end else if (g >= 0) begin
        m_a = a[g]; m_b = b[g]; m_sh = sh[g]; m_op = op[g];
        m_owner = g; m_last = g; m_busy = 1;
      end
    end
    acc = exp_rdy;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic vv, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [3:0] oo);
    v[i] = vv; a[i] = aa; b[i] = bb; sh[i] = 5'd0; op[i] = oo;
  endtask

  task automatic rand_bundle(input int i);
    logic [3:0] ops [7];
    ops = '{OP_AND, OP_OR, OP_ADDU, OP_SLL, OP_SRL, OP_SUBU, OP_SLTU};
    a[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    b[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    sh[i] = 5'($urandom_range(0, 31));
    op[i] = ops[$urandom_range(0, 6)];
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    v[0] = 1'b0; v[1] = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, '0, '0, OP_AND);
      rr[i] = 1'b0;
    end
    acc = 2'b00;
    repeat (3) @(negedge clk);
    reset_model();

    // Reset state, and ready held low while reset is asserted
    set_req(0, 1'b1, 32'd5, 32'd7, OP_ADDU);
    set_req(1, 1'b1, 32'd1, 32'd1, OP_ADDU);
    step();
    check("rst_ready_low", last_rdy, 2'b00);
    check("rst_rsp0_valid", bus.rsp0_valid, 1'b0);

    // Single op: ADDU 5+7
    rstn = 1'b1;
    v[1] = 1'b0;
    step();                                   // T
    check("t1_grant", last_rdy, 2'b01);
    v[0] = 1'b0;
    check("t1_alu_a", bus.alu_a, 32'd5);
    check("t1_alu_b", bus.alu_b, 32'd7);
    step();                                   // T+1
    check("t1_rsp0_valid", bus.rsp0_valid, 1'b1);
    check("t1_rsp0_data", bus.rsp0_data, 32'd12);
    check("t1_rsp0_zero", bus.rsp0_flags[2], 1'b0);
    step();                                   // T+2, not drained
    check("t1_rsp0_hold", bus.rsp0_valid, 1'b1);
    check("t1_rsp0_hold_data", bus.rsp0_data, 32'd12);
    rr[0] = 1'b1;
    step();
    check("t1_rsp0_drained", bus.rsp0_valid, 1'b0);

    // Tie after reset: req0 first, req1 two cycles later
    do_reset();
    rr[0] = 1'b1; rr[1] = 1'b1;
    set_req(0, 1'b1, 32'd10, 32'd20, OP_ADDU);
    set_req(1, 1'b1, 32'd100, 32'd1, OP_SUBU);
    step();                                   // T
    check("tie_first", last_rdy, 2'b01);
    v[0] = 1'b0;
    step();                                   // T+1
    check("tie_exec", last_rdy, 2'b00);
    check("tie_rsp0_valid", bus.rsp0_valid, 1'b1);
    check("tie_rsp0_data", bus.rsp0_data, 32'd30);
    step();                                   // T+2
    check("tie_second", last_rdy, 2'b10);
    v[1] = 1'b0;
    step();                                   // T+3
    check("tie_rsp1_valid", bus.rsp1_valid, 1'b1);
    check("tie_rsp1_data", bus.rsp1_data, 32'd99);

    // Fairness: both continuously valid, responses always taken
    do_reset();
    rr[0] = 1'b1; rr[1] = 1'b1;
    v[0] = 1'b1; v[1] = 1'b1;
    rand_bundle(0); rand_bundle(1);
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 2; i++) if (acc[i]) rand_bundle(i);
      step();
      if (c % 2 == 1)          check("fair_gap", last_rdy, 2'b00);
      else if ((c / 2) % 2 == 0) check("fair_grant0", last_rdy, 2'b01);
      else                      check("fair_grant1", last_rdy, 2'b10);
    end

    // Backpressure on slot 0, requester 1 still served
    do_reset();
    rr[0] = 1'b0; rr[1] = 1'b0;
    set_req(1, 1'b0, '0, '0, OP_AND);
    set_req(0, 1'b1, 32'd1, 32'd1, OP_ADDU);
    step();                                   // grant 0
    check("bp_grant0", last_rdy, 2'b01);
    set_req(0, 1'b1, 32'd2, 32'd2, OP_ADDU);
    step();                                   // exec
    set_req(1, 1'b1, 32'd3, 32'd3, OP_SUBU);
    step();                                   // slot 0 full -> req1 wins
    check("bp_grant1", last_rdy, 2'b10);
    v[1] = 1'b0;
    step();                                   // exec
    check("bp_rsp1_valid", bus.rsp1_valid, 1'b1);
    check("bp_rsp1_data", bus.rsp1_data, 32'd0);
    check("bp_rsp1_zero", bus.rsp1_flags[2], 1'b1);
    rr[1] = 1'b1;
    step();                                   // req0 still blocked
    check("bp_blocked", last_rdy, 2'b00);
    rr[0] = 1'b1;
    step();                                   // drain + accept same cycle
    check("bp_drain_accept", last_rdy, 2'b01);
    v[0] = 1'b0; rr[0] = 1'b0;
    step();
    check("bp_rsp0_new", bus.rsp0_data, 32'd4);
    rr[0] = 1'b1;
    step();

    // Flags and results
    do_reset();
    rr[0] = 1'b1; rr[1] = 1'b1;
    set_req(1, 1'b1, 32'd1, 32'd2, OP_SLTU);
    step();
    v[1] = 1'b0;
    step();
    check("sltu_data", bus.rsp1_data, 32'd1);
    set_req(0, 1'b1, 32'd0, 32'd1, OP_SUBU);
    step();
    v[0] = 1'b0;
    step();
    check("subu_data", bus.rsp0_data, 32'hFFFF_FFFF);
    check("subu_lt", bus.rsp0_flags[1], 1'b1);

    // Reset during S_EXEC aborts the operation
    do_reset();
    rr[0] = 1'b0; rr[1] = 1'b0;
    set_req(0, 1'b1, 32'd9, 32'd9, OP_ADDU);
    step();
    v[0] = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("midrst_rsp0", bus.rsp0_valid, 1'b0);
    check("midrst_rsp1", bus.rsp1_valid, 1'b0);
    check("midrst_alu_a", bus.alu_a, 32'd0);
    step();
    step();
    check("midrst_no_rsp", bus.rsp0_valid, 1'b0);
    set_req(0, 1'b1, 32'd4, 32'd4, OP_OR);
    set_req(1, 1'b1, 32'd6, 32'd6, OP_OR);
    step();
    check("midrst_tie", last_rdy, 2'b01);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] || acc[i]) begin
          v[i] = ($urandom_range(0, 99) < 60);
          rand_bundle(i);
        end
        rr[i] = ($urandom_range(0, 99) < 50);
      end
      rstn = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
